// File: rtl/aes_spi_responder.sv
// Serial AES front end: shifts in a 128-bit block plus key, launches the core, shifts the result back out.
// Latency: result leaves PAD cycles after core_start. No backpressure: cs_n frames the stream and a late core yields zeros.
module aes_spi_responder #(
    parameter int NK  = 4,
    parameter int PAD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             sdi,
    output logic             sdo,
    output logic             core_start,
    output logic [127:0]     core_data,
    output logic [NK*32-1:0] core_key,
    input  logic             core_done,
    input  logic [127:0]     core_result,
    output logic             busy,
    output logic             frame_done,
    output logic             late_err,
    output logic             abort_err
);
    localparam int KW = NK * 32;
    localparam int RW = 128 + KW;
    localparam logic [8:0] RX_BITS  = 9'(RW);
    localparam logic [7:0] WAIT_END = 8'(PAD - 1);

    typedef enum logic [2:0] {IDLE, RX_DATA, RX_KEY, WAIT, TX} state_t;

    state_t          state, state_nxt;
    logic [8:0]      bit_cnt;
    logic [7:0]      wait_cnt;
    logic [RW-1:0]   rx_sr;
    logic [127:0]    tx_sr;
    logic [127:0]    tx_word;
    logic            captured;

    logic rx_last_data, rx_full, wait_end, tx_end, abort;

    assign rx_last_data = (bit_cnt == 9'd127);
    assign rx_full      = (bit_cnt == RX_BITS);
    assign wait_end     = (wait_cnt == WAIT_END);
    assign tx_end       = (bit_cnt == 9'd128);
    // Dropping cs_n on the very edge that finishes the frame is a normal completion.
    assign abort        = cs_n && (state != IDLE) && !((state == TX) && tx_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_n)        state_nxt = RX_DATA;
            RX_DATA: if (rx_last_data) state_nxt = RX_KEY;
            RX_KEY:  if (rx_full)      state_nxt = WAIT;
            WAIT:    if (wait_end)     state_nxt = TX;
            TX:      if (tx_end)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // tx_word folds in a strobe arriving in the final WAIT cycle so it still makes the first bit.
    always_comb begin
        busy    = (state != IDLE);
        tx_word = captured ? tx_sr : (core_done ? core_result : 128'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdo        <= 1'b0;
            core_start <= 1'b0;
            core_data  <= '0;
            core_key   <= '0;
            frame_done <= 1'b0;
            late_err   <= 1'b0;
            abort_err  <= 1'b0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            captured   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                abort_err <= 1'b1;
                bit_cnt   <= '0;
                wait_cnt  <= '0;
                captured  <= 1'b0;
                sdo       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!cs_n) begin
                        rx_sr   <= {rx_sr[RW-2:0], sdi};
                        bit_cnt <= 9'd1;
                    end
                    RX_DATA, RX_KEY: begin
                        if (rx_full) begin
                            core_data  <= rx_sr[RW-1:KW];
                            core_key   <= rx_sr[KW-1:0];
                            core_start <= 1'b1;
                            bit_cnt    <= '0;
                            wait_cnt   <= '0;
                            captured   <= 1'b0;
                        end else begin
                            rx_sr   <= {rx_sr[RW-2:0], sdi};
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                    WAIT: begin
                        if (core_done && !captured) begin
                            tx_sr    <= core_result;
                            captured <= 1'b1;
                        end
                        if (wait_end) begin
                            sdo     <= tx_word[127];
                            tx_sr   <= {tx_word[126:0], 1'b0};
                            bit_cnt <= 9'd1;
                            if (!captured && !core_done) late_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    TX: begin
                        if (tx_end) begin
                            frame_done <= 1'b1;
                            sdo        <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            sdo     <= tx_sr[127];
                            tx_sr   <= {tx_sr[126:0], 1'b0};
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_spi_responder.sv
// Directed bench for aes_spi_responder: an NK=4 and an NK=8 instance, each driven by a small core model.
module tb_aes_spi_responder;
    localparam int PAD = 4;

    localparam logic [127:0] D1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K4  = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] D2  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [255:0] K2  = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] D3  = 128'h5555aaaa3333cccc0f0ff0f00000ffff;
    localparam logic [255:0] K3  = 256'h8000000000000000000000000000000b;
    localparam logic [127:0] R3  = 128'hc001d00d12345678a5a5a5a5f0e1d2c3;
    localparam logic [127:0] D4  = 128'h13579bdf2468ace013579bdf2468ace0;
    localparam logic [127:0] R4  = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] D5  = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [255:0] K5  = 256'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] RA1 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] RB1 = 128'hbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbb;
    localparam logic [127:0] D6  = 128'h8000000000000000000000000000ff01;
    localparam logic [255:0] K6  = 256'h00000000000000000000000000000001;
    localparam logic [127:0] RA2 = 128'ha5a55a5a0f0ff0f0cafef00d87654321;
    localparam logic [127:0] RB2 = 128'h77777777777777777777777777777777;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic [1:0]   cs_n_v  = 2'b11;
    logic         sdi     = 1'b0;
    logic [1:0]   cdone_v = 2'b00;
    logic [127:0] cres [2] = '{default: '0};

    wire  [1:0]   sdo_w, start_w, busy_w, fdone_w, late_w, abort_w;
    wire  [127:0] cdata0, cdata1, ckey0;
    wire  [255:0] ckey1;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];

    // Core model state: mode 0 = one strobe 2 cycles after start, 1 = silent, 2 = strobes at +1, +3 and +4.
    int           cm_k    [2] = '{-1, -1};
    int           cm_mode [2] = '{0, 0};
    int           starts  [2] = '{0, 0};
    logic [127:0] cm_a    [2] = '{default: '0};
    logic [127:0] cm_b    [2] = '{default: '0};

    always #5 clk = ~clk;

    aes_spi_responder #(.NK(4), .PAD(PAD)) dut4 (
        .clk(clk), .rst(rst), .cs_n(cs_n_v[0]), .sdi(sdi), .sdo(sdo_w[0]),
        .core_start(start_w[0]), .core_data(cdata0), .core_key(ckey0),
        .core_done(cdone_v[0]), .core_result(cres[0]), .busy(busy_w[0]),
        .frame_done(fdone_w[0]), .late_err(late_w[0]), .abort_err(abort_w[0])
    );

    aes_spi_responder #(.NK(8), .PAD(PAD)) dut8 (
        .clk(clk), .rst(rst), .cs_n(cs_n_v[1]), .sdi(sdi), .sdo(sdo_w[1]),
        .core_start(start_w[1]), .core_data(cdata1), .core_key(ckey1),
        .core_done(cdone_v[1]), .core_result(cres[1]), .busy(busy_w[1]),
        .frame_done(fdone_w[1]), .late_err(late_w[1]), .abort_err(abort_w[1])
    );

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            cdone_v[i] = 1'b0;
            if (start_w[i]) begin
                cm_k[i] = 0;
                starts[i]++;
            end else if (cm_k[i] >= 0 && cm_k[i] < 16) begin
                cm_k[i]++;
            end else begin
                cm_k[i] = -1;
            end
            if (cm_mode[i] == 0 && cm_k[i] == 2) begin
                cdone_v[i] = 1'b1;
                cres[i]    = cm_a[i];
            end
            if (cm_mode[i] == 2 && cm_k[i] == 1) begin
                cdone_v[i] = 1'b1;
                cres[i]    = cm_a[i];
            end
            if (cm_mode[i] == 2 && (cm_k[i] == 3 || cm_k[i] == 4)) begin
                cdone_v[i] = 1'b1;
                cres[i]    = cm_b[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dat_of(input int sel);
        return (sel != 0) ? cdata1 : cdata0;
    endfunction

    function automatic logic [255:0] key_of(input int sel);
        return (sel != 0) ? ckey1 : {128'd0, ckey0};
    endfunction

    // Called at a negedge; leaves off at the negedge after the last key bit (or just before the abort edge).
    task automatic send_bits(input int sel, input logic [127:0] d, input logic [255:0] k,
                             input int kbits, input logic [127:0] exp, input int abort_at);
        if (abort_at < 0) exp_q.push_back(exp);
        for (int i = 0; i < 128 + kbits; i++) begin
            if (i == abort_at) begin
                cs_n_v[sel] = 1'b1;
                sdi = 1'b0;
                return;
            end
            cs_n_v[sel] = 1'b0;
            sdi = (i < 128) ? d[127 - i] : k[kbits - 1 - (i - 128)];
            @(negedge clk);
            if (i == 0) chk("frame_start_busy", busy_w[sel], 1);
        end
        sdi = 1'b0;
    endtask

    task automatic finish_frame(input int sel, input logic [127:0] d, input logic [255:0] k,
                                input bit raise_at_end, input bit keep_low);
        logic [127:0] got;
        logic [127:0] exp;
        logic         wait_or;
        got = '0;
        exp = '0;
        chk("start_before_load", start_w[sel], 0);
        @(negedge clk);
        chk("core_start_pulse", start_w[sel], 1);
        chk("core_data", dat_of(sel), d);
        chk("core_key", key_of(sel), k);
        wait_or = sdo_w[sel];
        for (int j = 1; j < PAD; j++) begin
            @(negedge clk);
            if (j == 1) chk("core_start_width", start_w[sel], 0);
            wait_or = wait_or | sdo_w[sel];
        end
        chk("sdo_low_in_wait", wait_or, 0);
        for (int b = 127; b >= 0; b--) begin
            @(negedge clk);
            got[b] = sdo_w[sel];
        end
        if (raise_at_end) cs_n_v[sel] = 1'b1;
        chk("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        chk("readback", got, exp);
        @(negedge clk);
        chk("frame_done", fdone_w[sel], 1);
        chk("sdo_after_frame", sdo_w[sel], 0);
        chk("busy_after_frame", busy_w[sel], 0);
        chk("core_data_held", dat_of(sel), d);
        if (!keep_low) cs_n_v[sel] = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        @(negedge clk);
        chk("reset_ctrl", {sdo_w, start_w, busy_w, fdone_w, late_w, abort_w}, 0);
        chk("reset_core_data", {cdata0, cdata1}, 0);
        chk("reset_core_key4", ckey0, 0);
        chk("reset_core_key8", ckey1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reference vector, cs_n released on the frame_done edge.
        cm_mode[0] = 0;
        cm_a[0]    = R1;
        send_bits(0, D1, K4, 128, R1, -1);
        finish_frame(0, D1, K4, 1'b1, 1'b0);
        chk("ref_late_err", late_w[0], 0);
        chk("ref_abort_err", abort_w[0], 0);
        @(negedge clk);
        chk("frame_done_width", fdone_w[0], 0);

        // Core never answers.
        cm_mode[0] = 1;
        send_bits(0, D2, K2, 128, 128'd0, -1);
        finish_frame(0, D2, K2, 1'b0, 1'b0);
        chk("late_err_set", late_w[0], 1);
        chk("late_no_abort", abort_w[0], 0);
        @(negedge clk);

        // Abort at frame cycle 200, then a clean frame.
        cm_mode[0] = 0;
        cm_a[0]    = R3;
        n = starts[0];
        send_bits(0, D3, K3, 128, 128'd0, 200);
        @(negedge clk);
        chk("abort_idle", busy_w[0], 0);
        chk("abort_err_set", abort_w[0], 1);
        chk("abort_sdo", sdo_w[0], 0);
        chk("abort_no_frame_done", fdone_w[0], 0);
        repeat (300) @(negedge clk);
        chk("abort_no_core_start", starts[0], n);
        send_bits(0, D3, K3, 128, R3, -1);
        finish_frame(0, D3, K3, 1'b0, 1'b0);
        chk("abort_err_sticky", abort_w[0], 1);
        chk("late_err_sticky", late_w[0], 1);
        @(negedge clk);

        // Reset during TX bit 50.
        cm_a[0] = R4;
        send_bits(0, D4, K4, 128, R4, -1);
        repeat (PAD + 50) @(negedge clk);
        rst = 1'b1;
        cs_n_v[0] = 1'b1;
        #1;
        chk("rst_mid_tx_ctrl", {sdo_w[0], start_w[0], busy_w[0], fdone_w[0], late_w[0], abort_w[0]}, 0);
        chk("rst_mid_tx_core", {cdata0, ckey0}, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_flags", {late_w[0], abort_w[0], busy_w[0]}, 0);

        // Back-to-back frames, two strobes per WAIT plus one stray strobe in TX.
        cm_mode[0] = 2;
        cm_a[0]    = RA1;
        cm_b[0]    = RB1;
        send_bits(0, D5, K5, 128, RA1, -1);
        finish_frame(0, D5, K5, 1'b0, 1'b1);
        cm_a[0] = RA2;
        cm_b[0] = RB2;
        send_bits(0, D6, K6, 128, RA2, -1);
        finish_frame(0, D6, K6, 1'b0, 1'b0);
        chk("b2b_flags", {late_w[0], abort_w[0]}, 0);
        @(negedge clk);

        // 256-bit key on the NK=8 instance.
        cm_mode[1] = 0;
        cm_a[1]    = R8;
        send_bits(1, D1, K8, 256, R8, -1);
        finish_frame(1, D1, K8, 1'b0, 1'b0);
        chk("nk8_flags", {late_w[1], abort_w[1]}, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
